// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer: owns the global pipeline enable, accepts debug-unit
// commands over valid/ready, drains the pipeline after HALT and counts enabled cycles.
module pipeline_sequencer #(
  parameter int unsigned NB_CYCLES    = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt_detected,
  output logic                 o_pipe_enable,
  output logic                 o_pipe_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_CYCLES-1:0] o_cycle_count,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  // Counter is loaded on the HALT edge, so one less than the drain length.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           drain_q, drain_d;
  logic [NB_CYCLES-1:0] cycle_q;
  cmd_t                 cmd;

  assign cmd = cmd_t'(i_cmd);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (cmd)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_CLEAR: state_d = ST_CLEAR;
            CMD_NOP:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_STEP: begin
        if (i_halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q != 4'd0) drain_d = drain_q - 4'd1;
        else                 state_d = ST_DONE;
      end
      ST_DONE: begin
        // Non-CLEAR commands complete their handshake and are discarded.
        if (i_cmd_valid && cmd == CMD_CLEAR) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    o_cmd_ready   = 1'b0;
    o_pipe_enable = 1'b0;
    o_pipe_flush  = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      ST_IDLE:  o_cmd_ready = 1'b1;
      ST_RUN, ST_STEP, ST_DRAIN: begin
        o_pipe_enable = 1'b1;
        o_busy        = 1'b1;
      end
      ST_DONE: begin
        o_cmd_ready = 1'b1;
        o_done      = 1'b1;
      end
      ST_CLEAR: o_pipe_flush = 1'b1;
      default:  o_cmd_ready = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cycle_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      cycle_q <= '0;
    end else if (o_pipe_enable && cycle_q != '1) begin
      cycle_q <= cycle_q + NB_CYCLES'(1);
    end
  end

  assign o_cycle_count = cycle_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a behavioural model queues the expected
// outputs for every clock interval; a monitor compares them on the falling edge.
module tb_pipeline_sequencer;

  localparam int DRAIN = 4;
  localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = C_NOP;
  logic        halt = 1'b0;

  logic        rdy, en, fl, busy, done;
  logic [31:0] cnt;
  logic [2:0]  st;
  logic        rdy4, en4, fl4, busy4, done4;
  logic [3:0]  cnt4;
  logic [2:0]  st4;

  always #5 clk = ~clk;

  pipeline_sequencer #(.NB_CYCLES(32), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(rdy), .i_halt_detected(halt), .o_pipe_enable(en),
    .o_pipe_flush(fl), .o_busy(busy), .o_done(done),
    .o_cycle_count(cnt), .o_state(st)
  );

  pipeline_sequencer #(.NB_CYCLES(4), .DRAIN_CYCLES(DRAIN)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(rdy4), .i_halt_detected(halt), .o_pipe_enable(en4),
    .o_pipe_flush(fl4), .o_busy(busy4), .o_done(done4),
    .o_cycle_count(cnt4), .o_state(st4)
  );

  typedef struct {
    int     st;
    bit     en, fl, busy, done, rdy;
    longint cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   running = 1'b1;

  // Reference model: mode number, remaining enabled drain cycles, unbounded count.
  int     m_mode;
  int     m_drain_left;
  longint m_count;

  function automatic void m_reset();
    m_mode = 0; m_drain_left = 0; m_count = 0;
  endfunction

  function automatic exp_t exp_now();
    exp_t e;
    e.st   = m_mode;
    e.en   = (m_mode == 1 || m_mode == 2 || m_mode == 3);
    e.busy = e.en;
    e.fl   = (m_mode == 5);
    e.done = (m_mode == 4);
    e.rdy  = (m_mode == 0 || m_mode == 4);
    e.cnt  = m_count;
    return e;
  endfunction

  function automatic void m_edge(bit v, logic [1:0] c, bit h);
    if (m_mode == 1 || m_mode == 2 || m_mode == 3) m_count++;
    case (m_mode)
      0: if (v) begin
           if (c == C_RUN) m_mode = 1;
           else if (c == C_STEP) m_mode = 2;
           else if (c == C_CLR) m_mode = 5;
         end
      1: if (h) begin m_mode = 3; m_drain_left = DRAIN; end
      2: if (h) begin m_mode = 3; m_drain_left = DRAIN; end else m_mode = 0;
      3: begin
           m_drain_left--;
           if (m_drain_left == 0) m_mode = 4;
         end
      4: if (v && c == C_CLR) m_mode = 5;
      default: begin m_mode = 0; m_count = 0; end
    endcase
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void chk(string name, longint got, longint want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, want);
    end
  endfunction

  // Drive one cycle of inputs; they are sampled at the next rising edge.
  task automatic cycle(input bit v, input logic [1:0] c, input bit h);
    cmd_valid = v; cmd = c; halt = h;
    m_edge(v, c, h);
    q.push_back(exp_now());
    @(posedge clk); #1;
  endtask

  // Assert reset between edges, hold it across `hold` edges, release between edges.
  task automatic mid_reset(input int hold);
    #1;
    rst_n = 1'b0; cmd_valid = 1'b0; halt = 1'b0;
    m_reset();
    q.delete();
    q.push_back(exp_now());
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      q.push_back(exp_now());
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!running) break;
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard_empty t=%0t got=0 expected=1", $time);
      end else begin
        e = q.pop_front();
        chk("state",     st,    e.st);
        chk("enable",    en,    e.en);
        chk("flush",     fl,    e.fl);
        chk("busy",      busy,  e.busy);
        chk("done",      done,  e.done);
        chk("cmd_ready", rdy,   e.rdy);
        chk("count",     cnt,   sat(e.cnt, 64'hFFFF_FFFF));
        chk("count4",    cnt4,  sat(e.cnt, 15));
        chk("state4",    st4,   e.st);
      end
    end
  end

  initial begin : driver
    m_reset();
    q.push_back(exp_now());
    @(posedge clk); #1;
    q.push_back(exp_now());
    @(posedge clk); #1;
    #1 rst_n = 1'b1;

    // RUN with HALT on the 10th enabled edge: 14 enabled cycles total.
    cycle(1, C_RUN, 0);
    for (int i = 0; i < 9; i++) cycle(0, C_NOP, 0);
    cycle(0, C_NOP, 1);
    for (int i = 0; i < DRAIN + 2; i++) cycle(0, C_NOP, 0);
    cycle(1, C_CLR, 0);
    cycle(0, C_NOP, 0);

    // Three single steps without halt.
    for (int s = 0; s < 3; s++) begin
      cycle(1, C_STEP, 0);
      cycle(0, C_NOP, 0);
      cycle(0, C_NOP, 0);
    end

    // STEP attempts during RUN are ignored, then halt, drain and DONE handling.
    cycle(1, C_RUN, 0);
    for (int i = 0; i < 5; i++) cycle(1, C_STEP, 0);
    cycle(0, C_NOP, 1);
    for (int i = 0; i < DRAIN + 1; i++) cycle(0, C_NOP, 0);
    cycle(1, C_RUN, 0);
    cycle(1, C_STEP, 1);
    cycle(0, C_NOP, 0);
    cycle(1, C_CLR, 0);
    cycle(0, C_NOP, 0);
    cycle(0, C_NOP, 0);

    // Reset in the middle of a drain.
    cycle(1, C_RUN, 0);
    cycle(0, C_NOP, 0);
    cycle(0, C_NOP, 1);
    cycle(0, C_NOP, 0);
    mid_reset(1);
    for (int i = 0; i < 3; i++) cycle(0, C_NOP, 0);

    // Long run saturates the narrow counter; STEP with halt drains like RUN.
    cycle(1, C_RUN, 0);
    for (int i = 0; i < 20; i++) cycle(0, C_NOP, 0);
    cycle(0, C_NOP, 1);
    for (int i = 0; i < DRAIN + 1; i++) cycle(0, C_NOP, 0);
    cycle(1, C_CLR, 0);
    cycle(1, C_STEP, 1);
    for (int i = 0; i < DRAIN + 1; i++) cycle(1, C_NOP, 1);
    cycle(1, C_CLR, 1);
    cycle(1, C_RUN, 1);
    for (int i = 0; i < DRAIN + 1; i++) cycle(0, C_NOP, 0);

    // Random commands and halts, including simultaneous valid and halt.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < DRAIN + 2; i++) cycle(0, C_NOP, 0);

    #5;
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run/step/halt sequencer for the MIPS pipeline. It owns the global `enable` that freezes or advances the PC, the pipeline registers and `control_unit`. It accepts commands from the debug unit through a valid/ready handshake and runs the program continuously or one clock at a time. After a HALT is decoded in ID, it drains the pipeline for a fixed number of cycles, then stops and reports completion and the executed-cycle count.

## Interface
- `NB_CYCLES`, 32: width of executed-cycle counter.
- `DRAIN_CYCLES`, 4: enabled cycles after the HALT-sampling edge (ID→EX→MEM→WB plus one); legal range 1–15.
- `i_clock` in 1: single clock; all state changes on the rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_cmd_valid` in 1: command present on `i_cmd`.
- `i_cmd` in 2: 00 NOP, 01 RUN, 10 STEP, 11 CLEAR.
- `o_cmd_ready` out 1: sequencer can accept a command.
- `i_halt_detected` in 1: HALT opcode decoded in ID (level).
- `o_pipe_enable` out 1: global pipeline/control_unit enable.
- `o_pipe_flush` out 1: one-cycle synchronous clear request for PC and pipeline registers.
- `o_busy` out 1: state is STEP, RUN or DRAIN.
- `o_done` out 1: program finished; held until CLEAR.
- `o_cycle_count` out NB_CYCLES: number of edges with `o_pipe_enable`=1.
- `o_state` out 3: current state encoding, for the debug unit.

## Operation
- States and encodings:
  - IDLE = 0
  - RUN = 1
  - STEP = 2
  - DRAIN = 3
  - DONE = 4
  - CLEAR = 5
- Outputs are decoded from registered state only (Moore). No input reaches an output combinationally.
- A command is accepted only on an edge where `i_cmd_valid` && `o_cmd_ready`.
- `o_cmd_ready` = 1 in IDLE and DONE; 0 in every other state.
  - Commands presented while not ready are ignored, not queued.
- Transitions out of IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - CLEAR → CLEAR.
  - NOP → stay in IDLE.
- RUN: `o_pipe_enable` = 1.
  - If `i_halt_detected` is sampled at an edge, go to DRAIN and load the drain counter with DRAIN_CYCLES−1.
  - Otherwise stay in RUN.
- STEP: `o_pipe_enable` = 1 for exactly one cycle.
  - Next state is DRAIN (same load rule as RUN) if `i_halt_detected` is sampled; otherwise IDLE.
- DRAIN: `o_pipe_enable` = 1 and `i_halt_detected` is ignored.
  - While the counter is nonzero, decrement it.
  - When the counter reaches 0, go to DONE at that edge.
  - Total enabled cycles spent in DRAIN = DRAIN_CYCLES.
- DONE: `o_pipe_enable` = 0, `o_done` = 1.
  - CLEAR → CLEAR.
  - RUN, STEP and NOP are accepted (handshake completes) and dropped; state stays DONE.
- CLEAR: `o_pipe_flush` = 1, `o_pipe_enable` = 0.
  - Cycle counter and drain counter are zeroed at the exit edge; `o_done` goes to 0.
  - Next state is always IDLE.
- Cycle counter: increments on every edge where `o_pipe_enable` = 1.
  - Saturates at 2^NB_CYCLES−1 (no wrap).
- `o_busy` = 1 in STEP, RUN and DRAIN.
- Unused encodings 6 and 7 go to IDLE on the next edge with all outputs at their IDLE values.

## Timing
- Reset values, applied asynchronously while `i_reset` = 0 with no clock required:
  - state IDLE
  - `o_cmd_ready` = 1
  - `o_pipe_enable` = 0, `o_pipe_flush` = 0, `o_busy` = 0, `o_done` = 0
  - `o_cycle_count` = 0, `o_state` = 0
  - drain counter = 0
- Reset deassertion takes effect at the first rising edge after `i_reset` returns high.
- Command latency: a command accepted at edge N makes its effect visible in the cycle after edge N.
  - Example: RUN accepted at edge N → `o_pipe_enable` high starting immediately after edge N.
- HALT sampled at an enabled edge H: enable stays high for DRAIN_CYCLES more edges (H+1…H+DRAIN_CYCLES).
  - `o_done` rises after edge H+DRAIN_CYCLES.
  - `o_cycle_count` includes edge H.
- STEP with HALT sampled on the step edge behaves exactly like RUN (automatic drain).
- Reset mid-operation (any state): immediate return to reset values.
  - A partially completed drain is discarded.
  - No flush pulse is generated.
- Simultaneous `i_cmd_valid` and `i_halt_detected` in IDLE: the halt input is ignored (not sampled outside RUN/STEP).

## Test plan
- Reset, RUN accepted, `i_halt_detected` pulsed on the 10th enabled edge → enable high for 14 cycles, `o_cycle_count` = 14, `o_done` = 1, `o_state` = 4, `o_cmd_ready` = 1.
- Three STEP commands, no halt → three one-cycle enable pulses, `o_cycle_count` = 3, `o_state` returns to 0 after each step, `o_cmd_ready` low only during each STEP cycle.
- During RUN, assert `i_cmd_valid` with STEP for 5 cycles → never accepted, `o_cmd_ready` = 0, RUN continues unaffected.
- In DONE, issue RUN → handshake completes, state stays 4, count unchanged. Then issue CLEAR → single `o_pipe_flush` pulse, `o_cycle_count` = 0, `o_done` = 0, `o_state` = 0.
- Assert `i_reset` low mid-DRAIN between clock edges → all outputs at reset values before the next edge; after release, state is IDLE and no flush pulse occurs.
- With NB_CYCLES = 4, RUN for 20 cycles without halt → `o_cycle_count` reaches 15 and holds at 15.
